// File: rtl/array_count_greater_engine.sv
// Purpose : counts how many elements of one heap array area are strictly greater
//           (unsigned) than a threshold, reading the area through a synchronous-read port.
// Latency : done/count appear on the (k+2)th rising edge after the accepting edge,
//           where k = min(arraySize, NArea).
// Backpressure: none; start is only honoured in IDLE and ignored while busy or in DONE.
// Ports   : clock/reset (async active-low); start/array/arraySize/threshold request a scan;
//           heapRead/heapAddr/heapData form the heap read port (data one cycle after strobe);
//           busy spans accept..done, done is a one-cycle pulse, count holds the last result.
module array_count_greater_engine #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 3,
  parameter int NArrays            = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MemoryElementWidth-1:0] array,
  input  logic [MemoryElementWidth-1:0] arraySize,
  input  logic [MemoryElementWidth-1:0] threshold,
  output logic                          heapRead,
  output logic [MemoryElementWidth-1:0] heapAddr,
  input  logic [MemoryElementWidth-1:0] heapData,
  output logic                          busy,
  output logic                          done,
  output logic [MemoryElementWidth-1:0] count
);

  localparam int W = MemoryElementWidth;
  localparam logic [W-1:0] NAreaW = W'(NArea);
  localparam logic [W-1:0] One    = W'(1);

  // The accumulator is W bits wide and never exceeds NArea, so NArea must fit in W bits.
  if (NArrays < 1 || NArea < 1 || NArea >= (1 << W)) begin : g_bad_params
    $error("array_count_greater_engine: invalid parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t       state, state_next;
  logic [W-1:0] base;      // array * NArea, truncated to W
  logic [W-1:0] k;         // clamped element count
  logic [W-1:0] idx;       // next element index to read
  logic [W-1:0] thr;
  logic [W-1:0] acc, acc_next;
  logic [W-1:0] cap_dat;   // heap data registered before the compare
  logic         rd_d;      // a read was issued last cycle: heapData is valid now
  logic         cap_vld;   // cap_dat holds a read result to be compared
  logic         accept;
  logic         hit;

  assign accept   = (state == IDLE) && start;
  assign hit      = cap_vld && (cap_dat > thr);
  assign acc_next = acc + {{(W-1){1'b0}}, hit};

  always_comb begin
    state_next = state;
    heapRead   = 1'b0;
    heapAddr   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (k != '0) begin
          heapRead = 1'b1;
          heapAddr = base + idx;
        end
        if (k == '0 || idx == k - One) state_next = DRAIN;
      end
      DRAIN: begin
        // Wait until the last read's data has been captured; the final compare
        // is folded into the edge that enters DONE.
        busy = 1'b1;
        if (!rd_d) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      base    <= '0;
      k       <= '0;
      idx     <= '0;
      thr     <= '0;
      acc     <= '0;
      cap_dat <= '0;
      rd_d    <= 1'b0;
      cap_vld <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_next;
      rd_d    <= heapRead;
      cap_vld <= rd_d;
      if (rd_d) cap_dat <= heapData;

      if (accept) begin
        base <= array * NAreaW;
        thr  <= threshold;
        k    <= (arraySize > NAreaW) ? NAreaW : arraySize;
        idx  <= '0;
        acc  <= '0;
      end else begin
        if (heapRead) idx <= idx + One;
        acc <= acc_next;
      end

      if (state == DRAIN && state_next == DONE) count <= acc_next;
    end
  end

endmodule
